// File: rtl/sobel_pkg.sv
// Constants and types shared by the Sobel pipeline stages.
package sobel_pkg;

  localparam int unsigned DEF_ROWS = 400;
  localparam int unsigned DEF_COLS = 400;
  localparam int unsigned PIX_W    = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } cap_state_e;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port frame buffer: one write port, one registered read-first read port.
// Reads outside the populated depth return zero.
module capture_ram
  import sobel_pkg::*;
#(
  parameter int unsigned DEPTH  = DEF_ROWS * DEF_COLS,
  parameter int unsigned ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [PIX_W-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [PIX_W-1:0]  rdata
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PIX_W-1:0] mem [0:DEPTH-1];
  logic             w_in_range_c;
  logic             r_in_range_c;

  assign w_in_range_c = 32'(waddr) < DEPTH;
  assign r_in_range_c = 32'(raddr) < DEPTH;

  // Write port; storage itself is never reset.
  always_ff @(posedge clk) begin
    if (we && w_in_range_c) begin
      mem[waddr[IDX_W-1:0]] <= wdata;
    end
  end

  // Registered read port; sees pre-write contents on a same-address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= r_in_range_c ? mem[raddr[IDX_W-1:0]] : '0;
    end
  end

endmodule

// File: rtl/sobel_frame_capture.sv
// Captures one raster-ordered frame from the Sobel chain into a frame buffer
// and reports completion, stray strobes and non-grayscale pixels.
module sobel_frame_capture
  import sobel_pkg::*;
#(
  parameter int unsigned ROWS   = DEF_ROWS,
  parameter int unsigned COLS   = DEF_COLS,
  parameter int unsigned ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm_i,
  input  logic [7:0]        cam_red_i,
  input  logic [7:0]        cam_green_i,
  input  logic [7:0]        cam_blue_i,
  input  logic              sobel_done_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [7:0]        rd_data_o,
  output logic              rd_valid_o,
  output logic [15:0]       row_o,
  output logic [15:0]       col_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              overflow_o,
  output logic              color_err_o
);

  localparam logic [15:0] LAST_ROW = 16'(ROWS - 1);
  localparam logic [15:0] LAST_COL = 16'(COLS - 1);

  cap_state_e        state_q, state_d;
  logic [15:0]       row_d, col_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ovf_d, cerr_d;
  logic              we_c;

  // Next-state, counter advance, flag update and write enable.
  always_comb begin
    state_d = state_q;
    row_d   = row_o;
    col_d   = col_o;
    addr_d  = addr_q;
    ovf_d   = overflow_o;
    cerr_d  = color_err_o;
    we_c    = 1'b0;
    if (arm_i) begin
      state_d = CAPTURE;
      row_d   = '0;
      col_d   = '0;
      addr_d  = '0;
      ovf_d   = 1'b0;
      cerr_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        CAPTURE: begin
          if (sobel_done_i) begin
            we_c = !rst;
            if ((cam_red_i != cam_green_i) || (cam_red_i != cam_blue_i)) begin
              cerr_d = 1'b1;
            end
            if ((row_o == LAST_ROW) && (col_o == LAST_COL)) begin
              state_d = DONE;
              row_d   = '0;
              col_d   = '0;
              addr_d  = '0;
            end else if (col_o == LAST_COL) begin
              col_d  = '0;
              row_d  = row_o + 16'd1;
              addr_d = addr_q + ADDR_W'(1);
            end else begin
              col_d  = col_o + 16'd1;
              addr_d = addr_q + ADDR_W'(1);
            end
          end
        end
        DONE: begin
          if (sobel_done_i) begin
            ovf_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, counters and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      row_o        <= '0;
      col_o        <= '0;
      addr_q       <= '0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
      overflow_o   <= 1'b0;
      color_err_o  <= 1'b0;
      rd_valid_o   <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_o        <= row_d;
      col_o        <= col_d;
      addr_q       <= addr_d;
      busy_o       <= (state_d == CAPTURE);
      frame_done_o <= (state_d == DONE);
      overflow_o   <= ovf_d;
      color_err_o  <= cerr_d;
      rd_valid_o   <= rd_en_i;
    end
  end

  capture_ram #(
    .DEPTH  (ROWS * COLS),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we_c),
    .waddr (addr_q),
    .wdata (cam_red_i),
    .re    (rd_en_i),
    .raddr (rd_addr_i),
    .rdata (rd_data_o)
  );

endmodule
